// File: rtl/abr_prim_dom_and_nshare.sv
// abr_prim_xor2 / abr_prim_dom_and_nshare
//
// abr_prim_xor2: plain Width-bit XOR. It is kept as its own cell so that every
// masking and integration XOR is an explicit instance. Those instances can then
// be constrained or kept apart during implementation.
//   in0_i, in1_i  operands
//   out_o         in0_i ^ in1_i
//
// abr_prim_dom_and_nshare: domain-oriented masked AND, q = a & b, for NumShares
// shares of DW bits each. The inner-domain and cross-domain products are always
// registered, so one operation can be accepted every cycle. The result appears
// one cycle after the operands are accepted.
//   clk_i        clock
//   rst_b        asynchronous active-low reset
//   clear_i      synchronous scrub of all data flops and out_valid_o
//   in_valid_i   operand valid
//   in_ready_o   operand ready
//   a_i, b_i     operand shares, share s at [s*DW +: DW]
//   z_valid_i    fresh randomness valid
//   z_ready_o    randomness consumed this cycle (equal to operand accept)
//   z_i          NumZ random words, word k at [k*DW +: DW]
//   out_valid_o  result valid
//   out_ready_i  result accepted downstream
//   q_o          result shares, same layout as a_i
//   prd_o        registered a1&b0^z0, reused as a mask source by neighbours

module abr_prim_xor2 #(
  parameter int Width = 1
) (
  input  logic [Width-1:0] in0_i,
  input  logic [Width-1:0] in1_i,
  output logic [Width-1:0] out_o
);
  assign out_o = in0_i ^ in1_i;
endmodule

module abr_prim_dom_and_nshare #(
  parameter int  DW        = 64,
  parameter int  NumShares = 2,
  localparam int NumZ      = NumShares * (NumShares - 1) / 2
) (
  input  logic                    clk_i,
  input  logic                    rst_b,
  input  logic                    clear_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [NumShares*DW-1:0] a_i,
  input  logic [NumShares*DW-1:0] b_i,
  input  logic                    z_valid_i,
  output logic                    z_ready_o,
  input  logic [NumZ*DW-1:0]      z_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [NumShares*DW-1:0] q_o,
  output logic [DW-1:0]           prd_o
);

  if (NumShares < 2 || NumShares > 4) begin : gen_bad_shares
    $error("abr_prim_dom_and_nshare: NumShares must be in 2..4");
  end

  logic out_valid_reg;
  logic out_valid_next;
  logic accept;

  // prod_reg[i][i] holds the inner-domain term a_i&b_i. prod_reg[i][j] (i!=j)
  // holds the masked cross-domain term (a_i&b_j)^z_k(i,j).
  logic [DW-1:0] prod_reg  [NumShares][NumShares];
  logic [DW-1:0] prod_next [NumShares][NumShares];

  // ---------------------------------------------------------------------------
  // Handshake. Randomness is consumed only together with operands, so a stall
  // on z_valid_i or on the output never burns random words.
  // ---------------------------------------------------------------------------
  assign in_ready_o = !out_valid_reg | out_ready_i;
  assign accept     = in_valid_i & in_ready_o & z_valid_i & !clear_i;
  assign z_ready_o  = accept;

  always_comb begin
    out_valid_next = out_valid_reg;
    if (clear_i) begin
      out_valid_next = 1'b0;
    end else if (accept) begin
      out_valid_next = 1'b1;
    end else if (out_ready_i) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= out_valid_next;
    end
  end

  assign out_valid_o = out_valid_reg;

  // ---------------------------------------------------------------------------
  // Product terms. The mask XOR sits in front of the flop, so an unmasked
  // cross-domain product never reaches a register.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NumShares; gi++) begin : gen_row
    for (genvar gj = 0; gj < NumShares; gj++) begin : gen_col
      logic [DW-1:0] and_term;
      assign and_term = a_i[gi*DW +: DW] & b_i[gj*DW +: DW];

      if (gi == gj) begin : gen_inner
        assign prod_next[gi][gj] = and_term;
      end else begin : gen_cross
        // Pairs (i,j) and (j,i) share one word. The two shares of the mask
        // then cancel when the output shares are combined.
        localparam int Lo = (gi < gj) ? gi : gj;
        localparam int Hi = (gi < gj) ? gj : gi;
        localparam int K  = Lo + Hi * (Hi - 1) / 2;

        abr_prim_xor2 #(.Width(DW)) u_mask (
          .in0_i (and_term),
          .in1_i (z_i[K*DW +: DW]),
          .out_o (prod_next[gi][gj])
        );
      end

      always_ff @(posedge clk_i or negedge rst_b) begin
        if (!rst_b) begin
          prod_reg[gi][gj] <= '0;
        end else if (clear_i) begin
          prod_reg[gi][gj] <= '0;
        end else if (accept) begin
          prod_reg[gi][gj] <= prod_next[gi][gj];
        end
      end
    end

    // -------------------------------------------------------------------------
    // Integration: q_i is the XOR of its domain's registered terms. It is purely
    // combinational after the flops, so no path exists from a_i/b_i/z_i to q_o.
    // -------------------------------------------------------------------------
    logic [DW-1:0] acc [NumShares];
    assign acc[0] = prod_reg[gi][0];

    for (genvar gj = 1; gj < NumShares; gj++) begin : gen_int
      abr_prim_xor2 #(.Width(DW)) u_int (
        .in0_i (acc[gj-1]),
        .in1_i (prod_reg[gi][gj]),
        .out_o (acc[gj])
      );
    end

    assign q_o[gi*DW +: DW] = acc[NumShares-1];
  end

  assign prd_o = prod_reg[1][0];

  // A held result must not move under backpressure. clear_i is excluded
  // because its scrub takes priority and zeroes the result by design.
  q_stable_a : assert property (@(posedge clk_i) disable iff (!rst_b)
    out_valid_o && !out_ready_i && !clear_i |=> $stable(q_o));

endmodule

// File: tb/tb_abr_prim_dom_and_nshare.sv
module tb_abr_prim_dom_and_nshare;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  // Two-share instance (main tests)
  logic        c2_clear, c2_in_valid, c2_in_ready, c2_z_valid, c2_z_ready;
  logic        c2_out_valid, c2_out_ready;
  logic [15:0] c2_a, c2_b, c2_q;
  logic [7:0]  c2_z, c2_prd;

  // Three- and four-share instances
  logic        c3_clear, c3_in_valid, c3_in_ready, c3_z_valid, c3_z_ready;
  logic        c3_out_valid, c3_out_ready;
  logic [23:0] c3_a, c3_b, c3_q, c3_z;
  logic [7:0]  c3_prd;
  logic        c4_clear, c4_in_valid, c4_in_ready, c4_z_valid, c4_z_ready;
  logic        c4_out_valid, c4_out_ready;
  logic [31:0] c4_a, c4_b, c4_q;
  logic [47:0] c4_z;
  logic [7:0]  c4_prd;

  abr_prim_dom_and_nshare #(.DW(8), .NumShares(2)) dut2 (
    .clk_i(clk), .rst_b(rst_b), .clear_i(c2_clear),
    .in_valid_i(c2_in_valid), .in_ready_o(c2_in_ready),
    .a_i(c2_a), .b_i(c2_b),
    .z_valid_i(c2_z_valid), .z_ready_o(c2_z_ready), .z_i(c2_z),
    .out_valid_o(c2_out_valid), .out_ready_i(c2_out_ready),
    .q_o(c2_q), .prd_o(c2_prd));

  abr_prim_dom_and_nshare #(.DW(8), .NumShares(3)) dut3 (
    .clk_i(clk), .rst_b(rst_b), .clear_i(c3_clear),
    .in_valid_i(c3_in_valid), .in_ready_o(c3_in_ready),
    .a_i(c3_a), .b_i(c3_b),
    .z_valid_i(c3_z_valid), .z_ready_o(c3_z_ready), .z_i(c3_z),
    .out_valid_o(c3_out_valid), .out_ready_i(c3_out_ready),
    .q_o(c3_q), .prd_o(c3_prd));

  abr_prim_dom_and_nshare #(.DW(8), .NumShares(4)) dut4 (
    .clk_i(clk), .rst_b(rst_b), .clear_i(c4_clear),
    .in_valid_i(c4_in_valid), .in_ready_o(c4_in_ready),
    .a_i(c4_a), .b_i(c4_b),
    .z_valid_i(c4_z_valid), .z_ready_o(c4_z_ready), .z_i(c4_z),
    .out_valid_o(c4_out_valid), .out_ready_i(c4_out_ready),
    .q_o(c4_q), .prd_o(c4_prd));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Unmasked value of an n-share byte vector
  function automatic logic [7:0] unmask(input logic [31:0] sh, input int n);
    logic [7:0] r = 8'h00;
    for (int s = 0; s < n; s++) r ^= sh[s*8 +: 8];
    return r;
  endfunction

  // Random sharing of a plain byte into n shares
  function automatic logic [31:0] share(input logic [7:0] plain, input int n);
    logic [31:0] sh = '0;
    logic [7:0]  acc = plain;
    for (int s = 1; s < n; s++) begin
      sh[s*8 +: 8] = 8'($urandom);
      acc ^= sh[s*8 +: 8];
    end
    sh[7:0] = acc;
    return sh;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a0, a1, b0, b1, z;
    logic [7:0] exp_q, exp_prd;
  } vec_t;
  vec_t vecs[5];

  // Behavioural model state for the randomized two-share run
  logic       mdl_valid;
  logic [7:0] mdl_q, mdl_prd;

  initial begin
    logic [15:0] oa[4], ob[4];
    logic [7:0]  oz[4];
    logic [15:0] snap;
    logic        acc, rdy;

    vecs[0] = '{8'h3C, 8'h99, 8'h5A, 8'h55, 8'h6E, 8'h05, 8'h76};
    vecs[1] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{8'h0F, 8'hF0, 8'hAA, 8'h00, 8'h13, 8'hAA, 8'hB3};
    vecs[3] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h26, 8'h8E};
    vecs[4] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hC3, 8'h00, 8'hC3};

    rst_b = 1'b0;
    c2_clear = 0; c2_in_valid = 0; c2_z_valid = 0; c2_out_ready = 0; c2_a = 0; c2_b = 0; c2_z = 0;
    c3_clear = 0; c3_in_valid = 0; c3_z_valid = 0; c3_out_ready = 1; c3_a = 0; c3_b = 0; c3_z = 0;
    c4_clear = 0; c4_in_valid = 0; c4_z_valid = 0; c4_out_ready = 1; c4_a = 0; c4_b = 0; c4_z = 0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    #1;
    check("reset out_valid", 64'(c2_out_valid), 64'd0);
    check("reset q", 64'(c2_q), 64'd0);
    check("reset prd", 64'(c2_prd), 64'd0);
    check("reset in_ready", 64'(c2_in_ready), 64'd1);

    // Table of fixed vectors, one accept per cycle
    c2_out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      c2_a = {vecs[i].a1, vecs[i].a0};
      c2_b = {vecs[i].b1, vecs[i].b0};
      c2_z = vecs[i].z;
      c2_in_valid = 1; c2_z_valid = 1;
      #1;
      check($sformatf("vec%0d z_ready", i), 64'(c2_z_ready), 64'd1);
      tick();
      check($sformatf("vec%0d out_valid", i), 64'(c2_out_valid), 64'd1);
      check($sformatf("vec%0d q", i), 64'(unmask(32'(c2_q), 2)), 64'(vecs[i].exp_q));
      check($sformatf("vec%0d prd", i), 64'(c2_prd), 64'(vecs[i].exp_prd));
      $display("[TB] vec%0d a=%h b=%h z=%h q=%h prd=%h", i, c2_a, c2_b, c2_z, c2_q, c2_prd);
    end

    // Randomness stall: operands held, nothing captured
    c2_in_valid = 0; tick();
    c2_a = {vecs[0].a1, vecs[0].a0}; c2_b = {vecs[0].b1, vecs[0].b0}; c2_z = vecs[0].z;
    c2_in_valid = 1; c2_z_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("zstall z_ready", 64'(c2_z_ready), 64'd0);
      check("zstall in_ready", 64'(c2_in_ready), 64'd1);
      tick();
      check("zstall out_valid", 64'(c2_out_valid), 64'd0);
    end
    c2_z_valid = 1;
    #1 check("zstall release z_ready", 64'(c2_z_ready), 64'd1);
    tick();
    check("zstall out_valid after", 64'(c2_out_valid), 64'd1);
    check("zstall q", 64'(unmask(32'(c2_q), 2)), 64'h05);
    check("zstall prd", 64'(c2_prd), 64'h76);
    $display("[TB] z stall sequence q=%h", c2_q);

    // Back-to-back stream with backpressure on op 2
    for (int k = 0; k < 4; k++) begin
      logic [7:0] pa, pb;
      pa = 8'($urandom); pb = 8'($urandom);
      oa[k] = 16'(share(pa, 2)); ob[k] = 16'(share(pb, 2)); oz[k] = 8'($urandom);
    end
    c2_in_valid = 0; tick();
    for (int k = 0; k < 3; k++) begin
      c2_a = oa[k]; c2_b = ob[k]; c2_z = oz[k]; c2_in_valid = 1; c2_z_valid = 1; c2_out_ready = 1;
      tick();
      check($sformatf("stream op%0d valid", k), 64'(c2_out_valid), 64'd1);
      check($sformatf("stream op%0d q", k), 64'(unmask(32'(c2_q), 2)),
            64'(unmask(32'(oa[k]), 2) & unmask(32'(ob[k]), 2)));
      check($sformatf("stream op%0d prd", k), 64'(c2_prd), 64'((oa[k][15:8] & ob[k][7:0]) ^ oz[k]));
      $display("[TB] stream op%0d q=%h", k, c2_q);
    end
    snap = c2_q;
    c2_a = oa[3]; c2_b = ob[3]; c2_z = oz[3]; c2_out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("bp in_ready", 64'(c2_in_ready), 64'd0);
      check("bp z_ready", 64'(c2_z_ready), 64'd0);
      tick();
      check("bp out_valid", 64'(c2_out_valid), 64'd1);
      check("bp q stable", 64'(c2_q), 64'(snap));
    end
    c2_out_ready = 1;
    #1 check("bp release z_ready", 64'(c2_z_ready), 64'd1);
    tick();
    check("stream op3 q", 64'(unmask(32'(c2_q), 2)), 64'(unmask(32'(oa[3]), 2) & unmask(32'(ob[3]), 2)));
    check("stream op3 prd", 64'(c2_prd), 64'((oa[3][15:8] & ob[3][7:0]) ^ oz[3]));
    $display("[TB] stream op3 q=%h", c2_q);

    // Randomized run against the behavioural model
    c2_in_valid = 0; tick();
    mdl_valid = 0;
    mdl_q = unmask(32'(oa[3]), 2) & unmask(32'(ob[3]), 2);
    mdl_prd = (oa[3][15:8] & ob[3][7:0]) ^ oz[3];
    for (int c = 0; c < 200; c++) begin
      check("rnd out_valid", 64'(c2_out_valid), 64'(mdl_valid));
      check("rnd q", 64'(unmask(32'(c2_q), 2)), 64'(mdl_q));
      check("rnd prd", 64'(c2_prd), 64'(mdl_prd));
      c2_in_valid = ($urandom_range(0, 3) != 0);
      c2_z_valid = ($urandom_range(0, 3) != 0);
      c2_out_ready = ($urandom_range(0, 2) != 0);
      c2_clear = ($urandom_range(0, 15) == 0);
      c2_a = 16'($urandom); c2_b = 16'($urandom); c2_z = 8'($urandom);
      rdy = !mdl_valid || c2_out_ready;
      acc = c2_in_valid && rdy && c2_z_valid && !c2_clear;
      #1;
      check("rnd in_ready", 64'(c2_in_ready), 64'(rdy));
      check("rnd z_ready", 64'(c2_z_ready), 64'(acc));
      if (c2_clear) begin
        mdl_valid = 0; mdl_q = 0; mdl_prd = 0;
      end else if (acc) begin
        mdl_valid = 1;
        mdl_q = unmask(32'(c2_a), 2) & unmask(32'(c2_b), 2);
        mdl_prd = (c2_a[15:8] & c2_b[7:0]) ^ c2_z;
      end else if (c2_out_ready) begin
        mdl_valid = 0;
      end
      tick();
    end
    $display("[TB] random run done, model q=%h valid=%0d", mdl_q, mdl_valid);
    c2_clear = 0;

    // clear_i while a result is held under backpressure
    c2_a = oa[0]; c2_b = ob[0]; c2_z = oz[0]; c2_in_valid = 1; c2_z_valid = 1; c2_out_ready = 1;
    tick();
    check("clr pre valid", 64'(c2_out_valid), 64'd1);
    c2_out_ready = 0; c2_clear = 1; c2_in_valid = 1;
    #1 check("clr z_ready", 64'(c2_z_ready), 64'd0);
    tick();
    c2_clear = 0; c2_in_valid = 0;
    check("clr out_valid", 64'(c2_out_valid), 64'd0);
    check("clr q", 64'(c2_q), 64'd0);
    check("clr prd", 64'(c2_prd), 64'd0);
    $display("[TB] clear sequence q=%h prd=%h", c2_q, c2_prd);

    // Asynchronous reset with a result in flight
    c2_a = oa[1]; c2_b = ob[1]; c2_z = oz[1]; c2_in_valid = 1; c2_out_ready = 1;
    tick();
    check("arst pre valid", 64'(c2_out_valid), 64'd1);
    c2_in_valid = 0;
    #1 rst_b = 1'b0;
    #1;
    check("arst out_valid", 64'(c2_out_valid), 64'd0);
    check("arst q", 64'(c2_q), 64'd0);
    check("arst prd", 64'(c2_prd), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    #1 check("arst in_ready", 64'(c2_in_ready), 64'd1);
    $display("[TB] async reset sequence q=%h", c2_q);

    // Three- and four-share instances, first op a=F0 b=3C then random
    tick();
    for (int it = 0; it < 16; it++) begin
      logic [7:0] pa, pb;
      pa = (it == 0) ? 8'hF0 : 8'($urandom);
      pb = (it == 0) ? 8'h3C : 8'($urandom);
      c3_a = 24'(share(pa, 3)); c3_b = 24'(share(pb, 3)); c3_z = 24'($urandom);
      c4_a = share(pa, 4); c4_b = share(pb, 4); c4_z = {16'($urandom), 32'($urandom)};
      c3_in_valid = 1; c3_z_valid = 1; c4_in_valid = 1; c4_z_valid = 1;
      tick();
      check("ns3 valid", 64'(c3_out_valid), 64'd1);
      check("ns3 q", 64'(unmask(32'(c3_q), 3)), 64'(pa & pb));
      check("ns3 prd", 64'(c3_prd), 64'((c3_a[15:8] & c3_b[7:0]) ^ c3_z[7:0]));
      check("ns4 valid", 64'(c4_out_valid), 64'd1);
      check("ns4 q", 64'(unmask(c4_q, 4)), 64'(pa & pb));
      check("ns4 prd", 64'(c4_prd), 64'((c4_a[15:8] & c4_b[7:0]) ^ c4_z[7:0]));
      $display("[TB] ns3/ns4 op%0d a=%h b=%h q3=%h q4=%h", it, pa, pb, c3_q, c4_q);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
